cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 44 ++++
 rtl/cdb_arbiter.sv | 147 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Source-to-CDB bus bundle: per-source result handshakes and the
// registered common-data-bus broadcast.
interface cdb_arbiter_if #(
   parameter int Q_WIDTH = 4,
   parameter int N_SRC   = 3
);
   logic [N_SRC-1:0]         src_valid;
   logic [N_SRC-1:0]         src_ready;
   logic [N_SRC*Q_WIDTH-1:0] src_rob_pos;
   logic [N_SRC*32-1:0]      src_value;
   logic [N_SRC*32-1:0]      src_npc;

   logic               cdb_valid;
   logic [Q_WIDTH-1:0] cdb_rob_pos;
   logic [31:0]        cdb_value;
   logic [31:0]        cdb_npc;
   logic [1:0]         cdb_src;

   modport master (
      output src_valid,
      output src_rob_pos,
      output src_value,
      output src_npc,
      input  src_ready,
      input  cdb_valid,
      input  cdb_rob_pos,
      input  cdb_value,
      input  cdb_npc,
      input  cdb_src
   );

   modport slave (
      input  src_valid,
      input  src_rob_pos,
      input  src_value,
      input  src_npc,
      output src_ready,
      output cdb_valid,
      output cdb_rob_pos,
      output cdb_value,
      output cdb_npc,
      output cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU/BRU/LSB results onto one CDB,
// with a single holding register per source.
module cdb_arbiter #(
   parameter int Q_WIDTH = 4
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         flush_in,
   cdb_arbiter_if.slave bus,
   output logic         tag_err
);

   localparam int N_SRC = 3;

   logic [N_SRC-1:0]   hold_v_q, hold_v_d;
   logic [Q_WIDTH-1:0] tag_q [N_SRC];
   logic [Q_WIDTH-1:0] tag_d [N_SRC];
   logic [31:0]        val_q [N_SRC];
   logic [31:0]        val_d [N_SRC];
   logic [31:0]        npc_q [N_SRC];
   logic [31:0]        npc_d [N_SRC];
   logic [1:0]         rr_q, rr_d;

   logic               cdb_valid_q, cdb_valid_d;
   logic [Q_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
   logic [31:0]        cdb_val_q, cdb_val_d;
   logic [31:0]        cdb_npc_q, cdb_npc_d;
   logic [1:0]         cdb_src_q, cdb_src_d;
   logic               tag_err_q, tag_err_d;

   logic [N_SRC-1:0] grant;
   logic             gnt_v;
   logic [1:0]       gnt_idx;
   logic [1:0]       cand;
   logic [N_SRC-1:0] ready;
   logic [N_SRC-1:0] acc;
   logic             open;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      gnt_v   = 1'b0;
      gnt_idx = 2'd0;
      grant   = '0;
      cand    = rr_q;
      for (int k = 0; k < N_SRC; k++) begin
         if (!gnt_v && hold_v_q[cand]) begin
            gnt_v   = 1'b1;
            gnt_idx = cand;
         end
         cand = nxt(cand);
      end
      if (gnt_v) grant[gnt_idx] = 1'b1;
   end

   // A granted slot drains this cycle, so it can take a new entry at once.
   assign open  = rst_in & rdy_in & ~flush_in;
   assign ready = {N_SRC{open}} & (~hold_v_q | grant);
   assign acc   = bus.src_valid & ready;

   always_comb begin
      hold_v_d    = hold_v_q;
      tag_d       = tag_q;
      val_d       = val_q;
      npc_d       = npc_q;
      rr_d        = rr_q;
      cdb_valid_d = cdb_valid_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_val_d   = cdb_val_q;
      cdb_npc_d   = cdb_npc_q;
      cdb_src_d   = cdb_src_q;
      tag_err_d   = tag_err_q;
      if (!rdy_in) begin
         hold_v_d = hold_v_q;
      end else if (flush_in) begin
         hold_v_d    = '0;
         rr_d        = 2'd0;
         cdb_valid_d = 1'b0;
      end else begin
         cdb_valid_d = gnt_v;
         if (gnt_v) begin
            cdb_tag_d         = tag_q[gnt_idx];
            cdb_val_d         = val_q[gnt_idx];
            cdb_npc_d         = npc_q[gnt_idx];
            cdb_src_d         = gnt_idx;
            hold_v_d[gnt_idx] = 1'b0;
            rr_d              = nxt(gnt_idx);
         end
         for (int i = 0; i < N_SRC; i++) begin
            if (acc[i]) begin
               if (bus.src_rob_pos[i*Q_WIDTH +: Q_WIDTH] == '0) begin
                  tag_err_d = 1'b1;
               end else begin
                  hold_v_d[i] = 1'b1;
                  tag_d[i]    = bus.src_rob_pos[i*Q_WIDTH +: Q_WIDTH];
                  val_d[i]    = bus.src_value[i*32 +: 32];
                  npc_d[i]    = bus.src_npc[i*32 +: 32];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         hold_v_q    <= '0;
         rr_q        <= 2'd0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_val_q   <= '0;
         cdb_npc_q   <= '0;
         cdb_src_q   <= 2'd0;
         tag_err_q   <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            tag_q[i] <= '0;
            val_q[i] <= '0;
            npc_q[i] <= '0;
         end
      end else begin
         hold_v_q    <= hold_v_d;
         rr_q        <= rr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_val_q   <= cdb_val_d;
         cdb_npc_q   <= cdb_npc_d;
         cdb_src_q   <= cdb_src_d;
         tag_err_q   <= tag_err_d;
         for (int i = 0; i < N_SRC; i++) begin
            tag_q[i] <= tag_d[i];
            val_q[i] <= val_d[i];
            npc_q[i] <= npc_d[i];
         end
      end
   end

   assign bus.src_ready   = ready;
   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.cdb_rob_pos = cdb_tag_q;
   assign bus.cdb_value   = cdb_val_q;
   assign bus.cdb_npc     = cdb_npc_q;
   assign bus.cdb_src     = cdb_src_q;
   assign tag_err         = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: random and directed traffic against a
// queue-based reference model with a decoupled broadcast monitor.
module tb_cdb_arbiter;
   localparam int QW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rdy = 1'b1;
   logic flush = 1'b0;
   logic tag_err;

   cdb_arbiter_if #(.Q_WIDTH(QW)) bus ();

   cdb_arbiter #(.Q_WIDTH(QW)) dut (
      .clk_in   (clk),
      .rst_in   (rst_n),
      .rdy_in   (rdy),
      .flush_in (flush),
      .bus      (bus),
      .tag_err  (tag_err)
   );

   always #5 clk = ~clk;

   logic [2:0]    v = '0;
   logic [QW-1:0] tg [3];
   logic [31:0]   vl [3];
   logic [31:0]   np [3];

   assign bus.src_valid   = v;
   assign bus.src_rob_pos = {tg[2], tg[1], tg[0]};
   assign bus.src_value   = {vl[2], vl[1], vl[0]};
   assign bus.src_npc     = {np[2], np[1], np[0]};

   typedef struct {
      logic [QW-1:0] tag;
      logic [31:0]   val;
      logic [31:0]   npc;
      int            src;
      int            due;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int passed = 0;
   int edges = 0;
   int ntag = 1;
   bit upd_last = 0;

   // Reference state: one slot per source plus a rotating start index.
   bit            hv [3];
   logic [QW-1:0] ht [3];
   logic [31:0]   hval [3];
   logic [31:0]   hnpc [3];
   int            rr = 0;
   bit            terr = 0;
   bit            mvalid = 0;
   logic [QW-1:0] ltag = '0;
   logic [31:0]   lval = '0;
   logic [31:0]   lnpc = '0;
   int            lsrc = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic cycle();
      int g;
      bit [2:0] rexp;
      bit [2:0] acc;
      #1;
      g = -1;
      for (int k = 0; k < 3; k++)
         if (g < 0 && hv[(rr + k) % 3]) g = (rr + k) % 3;
      for (int i = 0; i < 3; i++)
         rexp[i] = rst_n && rdy && !flush && (!hv[i] || g == i);
      chk("src_ready", 32'(bus.src_ready), 32'(rexp));
      acc = v & rexp;
      @(posedge clk);
      edges++;
      upd_last = rst_n && rdy;
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) hv[i] = 0;
         rr = 0; terr = 0; mvalid = 0;
         ltag = '0; lval = '0; lnpc = '0; lsrc = 0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < 3; i++) hv[i] = 0;
            rr = 0; mvalid = 0;
         end else begin
            mvalid = (g >= 0);
            if (g >= 0) begin
               q.push_back('{ht[g], hval[g], hnpc[g], g, edges});
               ltag = ht[g]; lval = hval[g]; lnpc = hnpc[g]; lsrc = g;
               hv[g] = 0;
               rr = (g + 1) % 3;
            end
            for (int i = 0; i < 3; i++) begin
               if (acc[i]) begin
                  if (tg[i] == '0) terr = 1;
                  else begin
                     hv[i] = 1; ht[i] = tg[i];
                     hval[i] = vl[i]; hnpc[i] = np[i];
                  end
               end
            end
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit ev;
      if (edges > 0) begin
         chk("tag_err", 32'(tag_err), 32'(terr));
         if (!upd_last) begin
            chk("frozen_valid", 32'(bus.cdb_valid), 32'(mvalid));
            chk("frozen_tag", 32'(bus.cdb_rob_pos), 32'(ltag));
            chk("frozen_value", bus.cdb_value, lval);
            chk("frozen_npc", bus.cdb_npc, lnpc);
            chk("frozen_src", 32'(bus.cdb_src), 32'(lsrc));
         end else begin
            ev = (q.size() > 0) && (q[0].due == edges);
            chk("cdb_valid", 32'(bus.cdb_valid), 32'(ev));
            if (ev) begin
               e = q.pop_front();
               if (bus.cdb_valid) begin
                  chk("cdb_tag", 32'(bus.cdb_rob_pos), 32'(e.tag));
                  chk("cdb_value", bus.cdb_value, e.val);
                  chk("cdb_npc", bus.cdb_npc, e.npc);
                  chk("cdb_src", 32'(bus.cdb_src), 32'(e.src));
               end
            end
         end
      end
   end

   task automatic put(int i, logic [QW-1:0] t);
      tg[i] = t;
      vl[i] = $urandom;
      np[i] = $urandom;
   endtask

   function automatic logic [QW-1:0] fresh();
      logic [QW-1:0] t;
      t = QW'(ntag);
      ntag = (ntag == (1 << QW) - 1) ? 1 : ntag + 1;
      return t;
   endfunction

   task automatic idle(int n);
      v = '0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic saturate(int n);
      for (int k = 0; k < n; k++) begin
         v = 3'b111;
         for (int i = 0; i < 3; i++) put(i, fresh());
         cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         put(i, '0); hv[i] = 0; ht[i] = '0; hval[i] = '0; hnpc[i] = '0;
      end
      // reset with traffic offered: nothing may be accepted
      rst_n = 0;
      v = 3'b111;
      for (int i = 0; i < 3; i++) put(i, fresh());
      cycle(); cycle(); cycle();
      rst_n = 1;

      // single ALU result
      v = 3'b001;
      tg[0] = QW'(5); vl[0] = 32'h1234; np[0] = 32'h0;
      cycle();
      idle(4);

      // all sources every cycle
      saturate(12);

      // flush with all slots full
      v = '0; flush = 1;
      cycle();
      flush = 0;
      idle(3);

      // freeze mid-traffic
      saturate(3);
      rdy = 0;
      for (int k = 0; k < 4; k++) begin
         v = 3'($urandom);
         for (int i = 0; i < 3; i++) put(i, fresh());
         flush = (k == 2);
         cycle();
      end
      rdy = 1; flush = 0;
      saturate(4);
      idle(4);

      // BRU result with tag 0
      v = 3'b010;
      put(1, '0);
      cycle();
      idle(4);
      rst_n = 0;
      cycle();
      rst_n = 1;
      idle(2);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         v = 3'($urandom);
         for (int i = 0; i < 3; i++)
            put(i, ($urandom % 40 == 0) ? QW'(0) : fresh());
         flush = ($urandom % 25 == 0);
         rdy   = ($urandom % 8 != 0);
         rst_n = ($urandom % 150 != 0);
         cycle();
      end
      rst_n = 1; rdy = 1; flush = 0;
      idle(6);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
